// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sub_state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bi, bo is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first serial subtractor: diff = in1 - in2 - bin over WIDTH cycles.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             borrow;
    logic             cell_d;
    logic             cell_bo;

    full_subtractor u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (borrow),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= in1;
                        b_sr   <= in2;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    r_sr   <= {cell_d, r_sr[WIDTH-1:1]};
                    borrow <= cell_bo;
                    cnt    <= cnt + CNT_W'(1);
                    // Outputs only update on the MSB step so no partial result is ever visible.
                    if (cnt == LAST_BIT) begin
                        diff  <= {cell_d, r_sr[WIDTH-1:1]};
                        bout  <= cell_bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf   <= borrow ^ cell_bo;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: request to begin a subtraction, sampled on clk.
REQ-005 The block SHALL have the port in1, input, WIDTH bits: minuend, captured when start is accepted.
REQ-006 The block SHALL have the port in2, input, WIDTH bits: subtrahend, captured when start is accepted.
REQ-007 The block SHALL have the port bin, input, 1 bit: borrow-in, captured when start is accepted.
REQ-008 The block SHALL have the port diff, output, WIDTH bits: registered result in1 - in2 - bin, modulo 2^WIDTH.
REQ-009 The block SHALL have the port bout, output, 1 bit: registered borrow-out, 1 when in1 < in2 + bin (unsigned).
REQ-010 The block SHALL have the port busy, output, 1 bit: high while a subtraction is in progress.
REQ-011 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking diff/bout valid.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL capture in1, in2 and bin, clear the bit counter, and enter SHIFT.
REQ-014 SHIFT SHALL process one bit per cycle, LSB first, through a 1-bit full-subtractor cell whose borrow is registered between cycles.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, then enter DONE; start at edge N SHALL yield done=1 in the cycle after edge N+WIDTH.
REQ-016 done SHALL be high for exactly one cycle in DONE; the FSM SHALL then return to IDLE unless start is accepted at that edge.
REQ-017 busy SHALL be 1 in SHIFT only; done and busy SHALL never be 1 together.
REQ-018 start while in SHIFT SHALL be ignored, with no effect on the captured operands, the counter or the result.
REQ-019 diff and bout SHALL hold their last result from DONE until the final SHIFT edge of the next operation; they SHALL not show partial results while busy.
REQ-020 All arithmetic SHALL be unsigned modulo 2^WIDTH; bout SHALL equal the final borrow of the LSB-first chain.
REQ-021 A back-to-back start accepted in DONE SHALL give a new done exactly WIDTH+1 cycles after the previous done.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, busy=0, done=0, diff=0, bout=0, and clear the counter, operand registers and borrow register.
REQ-023 rst asserted mid-SHIFT SHALL abort the operation; no done pulse for that operation SHALL ever appear.
REQ-024 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-025 With the macro SERIAL_SUBTRACTOR_OVF_EN defined, the block SHALL add the output ovf (1 bit), the registered two's-complement overflow of in1 - in2 - bin: the borrow into the MSB XOR bout.
REQ-026 ovf SHALL follow the same reset, valid and hold rules as bout.
REQ-027 Without SERIAL_SUBTRACTOR_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 The shared package serial_sub_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE), the default WIDTH constant and the counter width constant $clog2(WIDTH+1).
REQ-029 The sub-module full_subtractor SHALL implement d = a^b^bi and bo = (~a&b) | (~(a^b)&bi); it SHALL be purely combinational and instantiated once.
REQ-030 The FSM, counter, shift registers and output registers SHALL reside in serial_subtractor.

Verification
REQ-031 The bench SHALL apply in1=0x05, in2=0x03, bin=0, start pulse -> require done 8 cycles later, diff=0x02, bout=0.
REQ-032 The bench SHALL apply in1=0x00, in2=0x01, bin=0 -> require diff=0xFF, bout=1; then in1=0xFF, in2=0xFF, bin=1 -> require diff=0xFF, bout=1.
REQ-033 The bench SHALL start 0x10-0x01, then pulse start with 0xAA/0x55 at cycle 3 -> require a single done with diff=0x0F and busy unbroken.
REQ-034 The bench SHALL assert rst at cycle 4 of SHIFT -> require busy=0, diff=0, and no done; a later start of 0x09-0x04 -> require diff=0x05.
REQ-035 The bench SHALL hold start high continuously with 0x20-0x10 -> require done every 9 cycles, diff=0x10 each time.
REQ-036 The bench SHALL, with SERIAL_SUBTRACTOR_OVF_EN defined, apply 0x80-0x01 -> require diff=0x7F, ovf=1, bout=0; and 0x7F-0x01 -> require ovf=0.
